pwrmgr_seq: RTL

//  Parametrised power sequencer between board pins and the soc core. Holds the core in reset

---
 rtl/pwrmgr_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pwrmgr_seq.sv
// Power sequencer: keeps the core in reset while OFF, wakes on debounced pins,
// stretches core reset on wake and drains TX before powering off.
module pwrmgr_seq #(
  parameter int                N_WAKE        = 1,
  parameter logic [N_WAKE-1:0] WAKE_POL      = '0,
  parameter int                WAKE_DEBOUNCE = 4,
  parameter int                RST_HOLD      = 16,
  parameter int                DRAIN_TIMEOUT = 1024,
  parameter int                CNT_W         = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_WAKE-1:0] wake_in,
  input  logic [N_WAKE-1:0] wake_mask,
  input  logic              poweroff_rq,
  input  logic              tx_busy,
  output logic              soc_resetn,
  output logic              io_en,
  output logic [1:0]        state_o,
  output logic [N_WAKE-1:0] wake_cause,
  output logic [CNT_W-1:0]  boot_cnt,
  output logic              drain_to
);

  localparam int DB_W = (WAKE_DEBOUNCE > 1) ? $clog2(WAKE_DEBOUNCE) : 1;
  localparam int HD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int DR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  localparam logic [DB_W-1:0] DB_LIM    = DB_W'(WAKE_DEBOUNCE - 1);
  localparam logic [HD_W-1:0] HD_LIM    = HD_W'(RST_HOLD - 1);
  localparam logic [DR_W-1:0] DR_LIM    = DR_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
  localparam bit              HAS_DRAIN = (DRAIN_TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N_WAKE-1:0] sync1_q, sync2_q;
  logic [N_WAKE-1:0] act;
  logic              any_act;
  logic [DB_W-1:0]   db_q, db_d;
  logic [HD_W-1:0]   hold_q, hold_d;
  logic [DR_W-1:0]   drain_q, drain_d;
  logic [N_WAKE-1:0] cause_q, cause_d;
  logic [CNT_W-1:0]  boot_q, boot_d;
  logic              dto_q, dto_d;

  // Pins are asynchronous; synchroniser idles at each source's inactive level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= ~WAKE_POL;
      sync2_q <= ~WAKE_POL;
    end else begin
      sync1_q <= wake_in;
      sync2_q <= sync1_q;
    end
  end

  assign act     = ~(sync2_q ^ WAKE_POL) & wake_mask;
  assign any_act = |act;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_OFF;
      db_q    <= '0;
      hold_q  <= '0;
      drain_q <= '0;
      cause_q <= '0;
      boot_q  <= '0;
      dto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      cause_q <= cause_d;
      boot_q  <= boot_d;
      dto_q   <= dto_d;
    end
  end

  // Debounce count only survives consecutive active OFF cycles, hence default clear.
  always_comb begin
    state_d = state_q;
    db_d    = '0;
    hold_d  = hold_q;
    drain_d = drain_q;
    cause_d = cause_q;
    boot_d  = boot_q;
    dto_d   = dto_q;
    case (state_q)
      ST_OFF: begin
        if (any_act) begin
          if (db_q == DB_LIM) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            cause_d = act;
            boot_d  = (boot_q == {CNT_W{1'b1}}) ? boot_q : boot_q + 1'b1;
            dto_d   = 1'b0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HD_LIM) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (poweroff_rq) begin
          drain_d = '0;
          state_d = HAS_DRAIN ? ST_DRAIN : ST_OFF;
        end
      end
      ST_DRAIN: begin
        // An idle TX takes priority over a timeout landing on the same edge.
        if (!tx_busy) begin
          state_d = ST_OFF;
        end else if (drain_q == DR_LIM) begin
          state_d = ST_OFF;
          dto_d   = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign soc_resetn = state_q[1];
  assign io_en      = state_q[1];
  assign state_o    = state_q;
  assign wake_cause = cause_q;
  assign boot_cnt   = boot_q;
  assign drain_to   = dto_q;

endmodule
